button_event_arbiter: RTL and testbench

Turns N raw push-button levels into single, glitch-free move and command events for the Pong game logic. Per button, the block synchronises the input, detects rising edges and generates auto-repeat events while the button is held. A round-robin arbiter then serialises all pending events onto one valid/ready channel. It sits between the board buttons and the paddle and game-state FSMs.

---
 rtl/pong_pkg.sv | 22 ++
 rtl/btn_event_gen.sv | 56 +++++
 rtl/button_event_arbiter.sv | 130 +++++++++++++
 tb/tb_button_event_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pong_pkg.sv
// Shared constants for the Pong board: button indices, clock rate and the
// auto-repeat timing defaults derived from it.
package pong_pkg;

  localparam int CLK_HZ = 50_000_000;

  typedef enum logic [1:0] {
    BTN_UP_P1 = 2'd0,
    BTN_DN_P1 = 2'd1,
    BTN_UP_P2 = 2'd2,
    BTN_DN_P2 = 2'd3
  } pongBtn_e;

  function automatic int msToCycles(input int ms);
    return (CLK_HZ / 1000) * ms;
  endfunction

  // 300 ms before the first repeat, then one repeat every 50 ms.
  localparam int REPEAT_DELAY_DEF  = msToCycles(300);
  localparam int REPEAT_PERIOD_DEF = msToCycles(50);

endpackage

// File: rtl/btn_event_gen.sv
// One button: two-flop synchroniser, rising-edge detect and the hold counter
// that produces auto-repeat pulses while the button stays pressed.
module btn_event_gen
  import pong_pkg::*;
#(
  parameter int CNT_W         = 24,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic clk,
  input  logic rstn,
  input  logic btn_i,
  output logic rise_pulse_o,
  output logic rep_pulse_o
);

  localparam logic [CNT_W-1:0] DELAY_C  = CNT_W'(REPEAT_DELAY);
  localparam logic [CNT_W-1:0] RELOAD_C = CNT_W'(REPEAT_DELAY - REPEAT_PERIOD);
  localparam bit               REPEAT_EN = (REPEAT_DELAY > 0);

  logic             s0_q, s1_q, s2_q;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d, holdNext;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s0_q      <= 1'b0;
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      holdCnt_q <= '0;
    end else begin
      s0_q      <= btn_i;
      s1_q      <= s0_q;
      s2_q      <= s1_q;
      holdCnt_q <= holdCnt_d;
    end
  end

  // The counter sits at 0 whenever s1 is low, so it is already clear in the
  // rise cycle. A repeat fires on the edge where the count would reach the
  // delay, and the reload keeps the following repeats exactly one period apart.
  always_comb begin
    holdNext     = holdCnt_q + CNT_W'(1);
    rise_pulse_o = s1_q & ~s2_q;
    rep_pulse_o  = 1'b0;
    holdCnt_d    = '0;
    if (s1_q) begin
      if (REPEAT_EN && (holdNext == DELAY_C)) begin
        rep_pulse_o = 1'b1;
        holdCnt_d   = RELOAD_C;
      end else begin
        holdCnt_d = holdNext;
      end
    end
  end

endmodule

// File: rtl/button_event_arbiter.sv
// Collects press and auto-repeat events from all buttons and serialises them
// round-robin onto a single registered valid/ready channel.
module button_event_arbiter
  import pong_pkg::*;
#(
  parameter int N_BTN         = 4,
  parameter int ID_W          = 2,
  parameter int CNT_W         = 24,
  parameter int REPEAT_DELAY  = REPEAT_DELAY_DEF,
  parameter int REPEAT_PERIOD = REPEAT_PERIOD_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [N_BTN-1:0] btn_in,
  input  logic             enable,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_repeat,
  output logic             overflow,
  input  logic             clr_ovf
);

  logic [N_BTN-1:0] rise, rep;
  logic [N_BTN-1:0] pend_q, pend_d, prep_q, prep_d;
  logic [ID_W-1:0]  lastGrant_q, lastGrant_d, evtId_q, evtId_d, winner;
  logic             evtValid_q, evtValid_d, evtRepeat_q, evtRepeat_d;
  logic             overflow_q, overflow_d;
  logic             found, load, ovfSet;
  int               cand;

  for (genvar g = 0; g < N_BTN; g++) begin : genBtn
    btn_event_gen #(
      .CNT_W        (CNT_W),
      .REPEAT_DELAY (REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
    ) uGen (
      .clk         (clk),
      .rstn        (rstn),
      .btn_i       (btn_in[g]),
      .rise_pulse_o(rise[g]),
      .rep_pulse_o (rep[g])
    );
  end

  // Scan from farthest to nearest so the last hit is the closest pending
  // index after the previous grant. Disabled means nothing is eligible.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = 0;
    for (int off = N_BTN; off >= 1; off--) begin
      cand = (int'(lastGrant_q) + off) % N_BTN;
      if (enable && pend_q[cand]) begin
        found  = 1'b1;
        winner = ID_W'(cand);
      end
    end
  end

  // A grant clears first, so a same-cycle event on the granted button simply
  // re-arms it instead of counting as an overflow.
  always_comb begin
    load   = ~evtValid_q | evt_ready;
    pend_d = pend_q;
    prep_d = prep_q;
    ovfSet = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!enable) begin
        pend_d[i] = 1'b0;
        prep_d[i] = 1'b0;
      end else begin
        if (load && found && (int'(winner) == i)) begin
          pend_d[i] = 1'b0;
        end
        if (rise[i] | rep[i]) begin
          if (pend_d[i]) begin
            ovfSet    = 1'b1;
            prep_d[i] = prep_q[i] & ~rise[i];
          end else begin
            prep_d[i] = ~rise[i];
          end
          pend_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    evtValid_d  = evtValid_q;
    evtId_d     = evtId_q;
    evtRepeat_d = evtRepeat_q;
    lastGrant_d = lastGrant_q;
    if (load) begin
      evtValid_d = found;
      if (found) begin
        evtId_d     = winner;
        evtRepeat_d = prep_q[winner];
        lastGrant_d = winner;
      end
    end
    overflow_d = ovfSet ? 1'b1 : (clr_ovf ? 1'b0 : overflow_q);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pend_q      <= '0;
      prep_q      <= '0;
      lastGrant_q <= '0;
      evtValid_q  <= 1'b0;
      evtId_q     <= '0;
      evtRepeat_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      pend_q      <= pend_d;
      prep_q      <= prep_d;
      lastGrant_q <= lastGrant_d;
      evtValid_q  <= evtValid_d;
      evtId_q     <= evtId_d;
      evtRepeat_q <= evtRepeat_d;
      overflow_q  <= overflow_d;
    end
  end

  assign evt_valid  = evtValid_q;
  assign evt_id     = evtId_q;
  assign evt_repeat = evtRepeat_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// Bench for button_event_arbiter: one instance without auto-repeat and one with
// a short repeat schedule, both tracked by a behavioural model every cycle.
module tb_button_event_arbiter;

  logic       clk;
  logic       rstn;
  logic [3:0] btn;
  logic       en, rdy, clr;

  logic       vOut[2];
  logic [1:0] idOut[2];
  logic       repOut[2];
  logic       ovfOut[2];

  int checkCount = 0;
  int errorCount = 0;

  // Model state, index 0 = no auto-repeat, 1 = delay 10 / period 4.
  int mD[2];
  int mP[2];
  bit mS0[2][4], mS1[2][4], mS2[2][4];
  int mHold[2][4];
  bit mPend[2][4], mPrep[2][4];
  int mLast[2];
  bit mValid[2], mRep[2], mOvf[2];
  int mId[2];

  int expIds[4];
  int expCyc[5];
  int expRep[5];

  button_event_arbiter #(
    .N_BTN(4), .ID_W(2), .CNT_W(8), .REPEAT_DELAY(0), .REPEAT_PERIOD(1)
  ) dut0 (
    .clk(clk), .rstn(rstn), .btn_in(btn), .enable(en), .evt_ready(rdy),
    .evt_valid(vOut[0]), .evt_id(idOut[0]), .evt_repeat(repOut[0]),
    .overflow(ovfOut[0]), .clr_ovf(clr)
  );

  button_event_arbiter #(
    .N_BTN(4), .ID_W(2), .CNT_W(8), .REPEAT_DELAY(10), .REPEAT_PERIOD(4)
  ) dut1 (
    .clk(clk), .rstn(rstn), .btn_in(btn), .enable(en), .evt_ready(rdy),
    .evt_valid(vOut[1]), .evt_id(idOut[1]), .evt_repeat(repOut[1]),
    .overflow(ovfOut[1]), .clr_ovf(clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checkCount++;
    if (observed != expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < 2; k++) begin
      for (int b = 0; b < 4; b++) begin
        mS0[k][b] = 0; mS1[k][b] = 0; mS2[k][b] = 0;
        mHold[k][b] = 0; mPend[k][b] = 0; mPrep[k][b] = 0;
      end
      mLast[k] = 0; mValid[k] = 0; mId[k] = 0; mRep[k] = 0; mOvf[k] = 0;
    end
  endtask

  // One clock edge of the reference: hold time is the number of cycles the
  // synchronised level has been high, and repeats fall where
  // hold >= delay and (hold - delay) is a multiple of the period.
  task automatic modelStep(input int k);
    bit rise[4];
    bit rep[4];
    int hn[4];
    bit load, found, granted, ovfSet;
    int win, c;
    for (int b = 0; b < 4; b++) begin
      rise[b] = mS1[k][b] && !mS2[k][b];
      hn[b]   = mS1[k][b] ? mHold[k][b] + 1 : 0;
      rep[b]  = (mD[k] > 0) && mS1[k][b] && (hn[b] >= mD[k]) && (((hn[b] - mD[k]) % mP[k]) == 0);
    end
    load  = !mValid[k] || rdy;
    found = 0;
    win   = 0;
    if (en) begin
      for (int off = 1; off <= 4; off++) begin
        c = (mLast[k] + off) % 4;
        if (!found && mPend[k][c]) begin
          found = 1;
          win   = c;
        end
      end
    end
    if (load) begin
      mValid[k] = found;
      if (found) begin
        mId[k]   = win;
        mRep[k]  = mPrep[k][win];
        mLast[k] = win;
      end
    end
    ovfSet = 0;
    for (int b = 0; b < 4; b++) begin
      if (!en) begin
        mPend[k][b] = 0;
        mPrep[k][b] = 0;
      end else begin
        granted = load && found && (win == b);
        if (granted) mPend[k][b] = 0;
        if (rise[b] || rep[b]) begin
          if (mPend[k][b]) begin
            ovfSet      = 1;
            mPrep[k][b] = mPrep[k][b] && !rise[b];
          end else begin
            mPrep[k][b] = !rise[b];
          end
          mPend[k][b] = 1;
        end
      end
    end
    if (ovfSet) mOvf[k] = 1;
    else if (clr) mOvf[k] = 0;
    for (int b = 0; b < 4; b++) begin
      mS2[k][b]   = mS1[k][b];
      mS1[k][b]   = mS0[k][b];
      mS0[k][b]   = btn[b];
      mHold[k][b] = hn[b];
    end
  endtask

  task automatic compareAll();
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("valid%0d", k), int'(vOut[k]), int'(mValid[k]));
      if (mValid[k]) begin
        checkOutput($sformatf("id%0d", k), int'(idOut[k]), mId[k]);
        checkOutput($sformatf("repeat%0d", k), int'(repOut[k]), int'(mRep[k]));
      end
      checkOutput($sformatf("overflow%0d", k), int'(ovfOut[k]), int'(mOvf[k]));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rstn) begin
      modelStep(0);
      modelStep(1);
    end
    @(negedge clk);
    compareAll();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Called just after a falling edge; outputs must drop as soon as rstn does.
  task automatic applyReset();
    rstn = 1'b0;
    #1;
    modelReset();
    for (int k = 0; k < 2; k++) begin
      checkOutput("rstValid", int'(vOut[k]), 0);
      checkOutput("rstId", int'(idOut[k]), 0);
      checkOutput("rstRepeat", int'(repOut[k]), 0);
      checkOutput("rstOverflow", int'(ovfOut[k]), 0);
    end
    btn = '0;
    ticks(2);
    rstn = 1'b1;
  endtask

  task automatic applyStimulus(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 15) == 0) btn[b] = ~btn[b];
      end
      rdy = ($urandom_range(0, 3) != 0);
      en  = ($urandom_range(0, 31) != 0);
      clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 999) == 0) applyReset();
      tick();
    end
  endtask

  initial begin
    int ids[$];
    int cyc[$];
    int reps[$];
    int hs;

    mD[0] = 0;  mP[0] = 1;
    mD[1] = 10; mP[1] = 4;
    expIds[0] = 2; expIds[1] = 3; expIds[2] = 0; expIds[3] = 1;
    expCyc[0] = 3; expCyc[1] = 12; expCyc[2] = 16; expCyc[3] = 20; expCyc[4] = 24;
    expRep[0] = 0; expRep[1] = 1; expRep[2] = 1; expRep[3] = 1; expRep[4] = 1;

    btn = '0; en = 1'b1; rdy = 1'b1; clr = 1'b0; rstn = 1'b0;
    applyReset();

    $display("[TB] single press, no auto-repeat");
    btn = 4'b0100;
    for (int e = 1; e <= 12; e++) begin
      tick();
      checkOutput($sformatf("t1Valid@%0d", e), int'(vOut[0]), int'(e == 4));
      if (e == 4) begin
        checkOutput("t1Id", int'(idOut[0]), 2);
        checkOutput("t1Repeat", int'(repOut[0]), 0);
      end
    end

    $display("[TB] simultaneous presses after a grant to button 1");
    btn = '0;     ticks(4);
    btn = 4'b0010; ticks(6);
    btn = '0;     ticks(4);
    btn = 4'b1111;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (vOut[0]) begin
        ids.push_back(int'(idOut[0]));
        cyc.push_back(c);
        reps.push_back(int'(repOut[0]));
      end
    end
    checkOutput("t2Count", ids.size(), 4);
    for (int i = 0; i < ids.size() && i < 4; i++) begin
      checkOutput($sformatf("t2Id%0d", i), ids[i], expIds[i]);
      checkOutput($sformatf("t2Repeat%0d", i), reps[i], 0);
      checkOutput($sformatf("t2Cycle%0d", i), cyc[i], cyc[0] + i);
    end

    $display("[TB] backpressure");
    btn = '0; ticks(4);
    rdy = 1'b0;
    btn = 4'b0011;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (c >= 5) begin
        checkOutput("t3HeldValid", int'(vOut[0]), 1);
        checkOutput("t3HeldId", int'(idOut[0]), 0);
      end
    end
    rdy = 1'b1;
    tick();
    checkOutput("t3NextValid", int'(vOut[0]), 1);
    checkOutput("t3NextId", int'(idOut[0]), 1);
    checkOutput("t3Overflow", int'(ovfOut[0]), 0);
    btn = '0; ticks(10);

    $display("[TB] auto-repeat on button 3");
    ids.delete(); cyc.delete(); reps.delete();
    btn = 4'b1000;
    for (int c = 0; c < 40; c++) begin
      if (c == 25) btn = '0;
      tick();
      if (vOut[1] && idOut[1] == 2'd3) begin
        cyc.push_back(c);
        reps.push_back(int'(repOut[1]));
      end
    end
    checkOutput("t4Count", cyc.size(), 5);
    for (int i = 0; i < cyc.size() && i < 5; i++) begin
      checkOutput($sformatf("t4Cycle%0d", i), cyc[i], expCyc[i]);
      checkOutput($sformatf("t4Repeat%0d", i), reps[i], expRep[i]);
    end

    $display("[TB] overflow and clear");
    rdy = 1'b0;
    for (int p = 0; p < 3; p++) begin
      btn = 4'b0001; ticks(4);
      btn = '0;      ticks(4);
    end
    checkOutput("t5OverflowSet", int'(ovfOut[0]), 1);
    rdy = 1'b1;
    hs  = 0;
    for (int c = 0; c < 8; c++) begin
      if (vOut[0]) hs++;
      tick();
    end
    checkOutput("t5Handshakes", hs, 2);
    checkOutput("t5OverflowSticky", int'(ovfOut[0]), 1);
    clr = 1'b1; tick();
    clr = 1'b0;
    checkOutput("t5OverflowClear", int'(ovfOut[0]), 0);

    $display("[TB] reset mid-handshake and enable low");
    rdy = 1'b0;
    btn = 4'b0100; ticks(6);
    checkOutput("t6PreValid", int'(vOut[0]), 1);
    applyReset();
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t6PostReset", int'(vOut[0]), 0);
    end
    en  = 1'b0;
    btn = 4'b0010;
    for (int c = 0; c < 10; c++) begin
      tick();
      checkOutput("t6Disabled", int'(vOut[0]), 0);
    end
    btn = '0; ticks(4);
    en = 1'b1; rdy = 1'b1; ticks(4);

    $display("[TB] randomized traffic");
    applyStimulus(3000);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule
